// File: rtl/pipe_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package pipe_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       valid;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic [4:0] rd;
  } exmem_ctrl_t;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic is_aligned(input logic [2:0] lsb);
    return (lsb == 3'b000);
  endfunction

endpackage

// File: rtl/dmem_fsm.sv
// Data-memory bus sequencer: request/ack handshake, stall generation.
// Optional wait-cycle abort is compiled in with MEM_TIMEOUT_EN.
module dmem_fsm
  import pipe_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,    // entry being captured is a valid aligned access
  input  logic i_store,    // latched MemWrite
  input  logic i_ack,
  output logic o_wait,
  output logic o_req,
  output logic o_we,
  output logic o_stall,
  output logic o_done,     // latched access retires on this edge
  output logic o_timeout
);

  mem_state_t r_state;
  mem_state_t w_next;
  logic       w_limit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt;

  assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter: zero in the first WAIT cycle, counts stalled edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (o_stall) r_cnt <= r_cnt + CNT_W'(1);
    else              r_cnt <= '0;
  end
`else
  assign w_limit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and bus/stall outputs. A completing access may hand over
  // directly to a new one captured on the same edge, so WAIT can re-enter WAIT.
  always_comb begin
    w_next    = r_state;
    o_wait    = 1'b0;
    o_req     = 1'b0;
    o_we      = 1'b0;
    o_stall   = 1'b0;
    o_done    = 1'b0;
    o_timeout = 1'b0;
    case (r_state)
      ST_IDLE: w_next = i_start ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        o_wait    = 1'b1;
        o_req     = 1'b1;
        o_we      = i_store;
        o_timeout = !i_ack && w_limit;
        o_done    = i_ack || o_timeout;
        o_stall   = !o_done;
        if (o_done) w_next = i_start ? ST_WAIT : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register, load/store access unit and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES wait cycles
// (adds the timeout_err output).
module mem_access_stage #(
  parameter int unsigned XLEN           = pipe_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] ALU_result_ex,
  input  logic [XLEN-1:0] write_data_ex,
  input  logic [4:0]      rd_ex,
  input  logic            RegWrite_ex,
  input  logic            MemRead_ex,
  input  logic            MemWrite_ex,
  input  logic            MemtoReg_ex,
  output logic [XLEN-1:0] ALU_result_mem,
  output logic [4:0]      rd_mem,
  output logic            RegWrite_mem,
  output logic            MemRead_mem,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_RegWrite,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err
`ifdef MEM_TIMEOUT_EN
  ,
  output logic            timeout_err
`endif
);
  import pipe_pkg::*;

  exmem_ctrl_t     r_ctrl;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_wdata;
  logic            r_wb_valid;
  logic            r_wb_regwrite;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign;

  logic w_start, w_wait, w_stall, w_done, w_timeout;
  logic w_memop, w_misaligned;

  assign w_start      = valid_ex && (MemRead_ex || MemWrite_ex) && is_aligned(ALU_result_ex[2:0]);
  assign w_memop      = r_ctrl.MemRead || r_ctrl.MemWrite;
  assign w_misaligned = w_memop && !is_aligned(r_alu[2:0]);

  dmem_fsm
`ifdef MEM_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
  u_fsm (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (w_start),
    .i_store   (r_ctrl.MemWrite),
    .i_ack     (dmem_ack),
    .o_wait    (w_wait),
    .o_req     (dmem_req),
    .o_we      (dmem_we),
    .o_stall   (w_stall),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  // EX/MEM register: frozen while an access is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
    end else if (!w_stall) begin
      r_ctrl  <= '{valid: valid_ex, RegWrite: RegWrite_ex, MemRead: MemRead_ex,
                   MemWrite: MemWrite_ex, MemtoReg: MemtoReg_ex, rd: rd_ex};
      r_alu   <= ALU_result_ex;
      r_wdata <= write_data_ex;
    end
  end

  // MEM/WB register: retire the latched entry or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (w_wait) begin
        if (w_done) begin
          r_wb_valid    <= 1'b1;
          r_wb_rd       <= r_ctrl.rd;
          r_wb_regwrite <= r_ctrl.RegWrite && !r_ctrl.MemWrite && !w_timeout;
          r_wb_data     <= (r_ctrl.MemtoReg && !w_timeout) ? dmem_rdata : r_alu;
        end else begin
          r_wb_valid    <= 1'b0;
          r_wb_regwrite <= 1'b0;
        end
      end else begin
        r_wb_valid    <= r_ctrl.valid;
        r_wb_rd       <= r_ctrl.rd;
        r_wb_regwrite <= r_ctrl.valid && r_ctrl.RegWrite && !r_ctrl.MemWrite && !w_misaligned;
        r_wb_data     <= r_alu;
        r_misalign    <= r_ctrl.valid && w_misaligned;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_timeout_err;

  // One-cycle abort flag, aligned with the WB update of the aborted entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timeout_err <= 1'b0;
    else        r_timeout_err <= w_timeout;
  end

  assign timeout_err = r_timeout_err;
`endif

  assign mem_stall      = w_stall;
  assign ALU_result_mem = r_alu;
  assign rd_mem         = r_ctrl.rd;
  assign RegWrite_mem   = r_ctrl.RegWrite && r_ctrl.valid;
  assign MemRead_mem    = r_ctrl.MemRead && r_ctrl.valid;
  assign dmem_addr      = r_alu;
  assign dmem_wdata     = r_wdata;
  assign wb_valid       = r_wb_valid;
  assign wb_RegWrite    = r_wb_regwrite;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (directed scenarios plus a
// randomized run against a transaction-level reference model).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex;
  logic [63:0] ALU_result_ex, write_data_ex;
  logic [4:0]  rd_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [63:0] ALU_result_mem;
  logic [4:0]  rd_mem;
  logic        RegWrite_mem, MemRead_mem, mem_stall;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign_err;
`ifdef MEM_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        v, rw, mr, mw, m2r;
    logic [4:0]  rd;
    logic [63:0] alu, wd;
  } ins_t;

  mem_access_stage dut (
`ifdef MEM_TIMEOUT_EN
    .timeout_err    (timeout_err),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_ex       (valid_ex),
    .ALU_result_ex  (ALU_result_ex),
    .write_data_ex  (write_data_ex),
    .rd_ex          (rd_ex),
    .RegWrite_ex    (RegWrite_ex),
    .MemRead_ex     (MemRead_ex),
    .MemWrite_ex    (MemWrite_ex),
    .MemtoReg_ex    (MemtoReg_ex),
    .ALU_result_mem (ALU_result_mem),
    .rd_mem         (rd_mem),
    .RegWrite_mem   (RegWrite_mem),
    .MemRead_mem    (MemRead_mem),
    .mem_stall      (mem_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_RegWrite    (wb_RegWrite),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input ins_t t);
    valid_ex      = t.v;
    RegWrite_ex   = t.rw;
    MemRead_ex    = t.mr;
    MemWrite_ex   = t.mw;
    MemtoReg_ex   = t.m2r;
    rd_ex         = t.rd;
    ALU_result_ex = t.alu;
    write_data_ex = t.wd;
  endtask

  function automatic ins_t mk(input logic v, rw, mr, mw, m2r, input logic [4:0] rd,
                              input logic [63:0] alu, wd);
    ins_t t;
    t.v = v; t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r;
    t.rd = rd; t.alu = alu; t.wd = wd;
    return t;
  endfunction

  function automatic ins_t bubble();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int unsigned k;
    k     = $urandom_range(0, 9);
    t.v   = ($urandom_range(0, 6) != 0);
    t.rd  = 5'($urandom);
    t.rw  = 1'($urandom);
    t.mr  = 1'b0; t.mw = 1'b0; t.m2r = 1'b0;
    t.alu = {$urandom, $urandom};
    t.wd  = {$urandom, $urandom};
    if (k < 3) begin t.mr = 1'b1; t.m2r = 1'b1; t.rw = 1'b1; end
    else if (k < 5) t.mw = 1'b1;
    if (t.mr || t.mw)
      t.alu[2:0] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    return t;
  endfunction

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'hFFFF; drive(bubble());
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (dmem_req !== 1'b0)   $display("FAIL reset_req: got %b expected 0", dmem_req);
    if (dmem_req !== 1'b0) n_fail++;
    n_tests++; if (mem_stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    n_tests++; if (wb_valid !== 1'b0 || wb_data !== 64'd0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_wb: valid %b data %0h mis %b expected 0", wb_valid, wb_data, misalign_err); end
    n_tests++; if (RegWrite_mem !== 1'b0 || ALU_result_mem !== 64'd0 || dmem_addr !== 64'd0) begin
      n_fail++; $display("FAIL reset_exmem: rw %b alu %0h addr %0h expected 0", RegWrite_mem, ALU_result_mem, dmem_addr); end
    tick(); tick();
    rst_n = 1'b1;
    // stale ack right after reset must be ignored
    tick();
    n_tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_ack: req %b stall %b wbv %b expected 0", dmem_req, mem_stall, wb_valid); end
    dmem_ack = 1'b0;
  endtask

  task automatic test_alu_op();
    drive(mk(1, 1, 0, 0, 0, 5'd5, 64'h2A, 64'h0));
    #1;
    n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", mem_stall); end
    tick();
    drive(bubble());
    n_tests++; if (RegWrite_mem !== 1'b1 || rd_mem !== 5'd5 || ALU_result_mem !== 64'h2A) begin
      n_fail++; $display("FAIL alu_exmem: rw %b rd %0d alu %0h expected 1 5 2a", RegWrite_mem, rd_mem, ALU_result_mem); end
    n_tests++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL alu_nostall: stall %b req %b expected 0 0", mem_stall, dmem_req); end
    tick();
    n_tests++; if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd5 || wb_RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb: v %b data %0h rd %0d rw %b expected 1 2a 5 1", wb_valid, wb_data, wb_rd, wb_RegWrite); end
  endtask

  task automatic test_load_wait();
    int req_cyc = 0, stall_cyc = 0, bubbles = 0;
    drive(mk(1, 1, 1, 0, 1, 5'd7, 64'h100, 64'h0));
    tick();
    n_tests++; if (MemRead_mem !== 1'b1) begin n_fail++; $display("FAIL load_memread: got %b expected 1", MemRead_mem); end
    drive(mk(1, 1, 0, 0, 0, 5'd9, 64'h77, 64'h0));
    for (int c = 0; c < 3; c++) begin
      dmem_ack = (c == 2); dmem_rdata = (c == 2) ? 64'hDEAD : 64'h1234;
      #1;
      if (dmem_req === 1'b1) req_cyc++;
      if (mem_stall === 1'b1) stall_cyc++;
      if (c == 0) begin
        n_tests++; if (dmem_addr !== 64'h100 || dmem_we !== 1'b0) begin
          n_fail++; $display("FAIL load_bus: addr %0h we %b expected 100 0", dmem_addr, dmem_we); end
      end
      tick();
      if (c < 2 && wb_valid === 1'b0 && wb_RegWrite === 1'b0) bubbles++;
      if (c < 2) begin
        n_tests++; if (ALU_result_mem !== 64'h100) begin
          n_fail++; $display("FAIL load_hold: alu_mem %0h expected 100", ALU_result_mem); end
      end
    end
    dmem_ack = 1'b0;
    n_tests++; if (req_cyc != 3 || stall_cyc != 2 || bubbles != 2) begin
      n_fail++; $display("FAIL load_cycles: req %0d stall %0d bubbles %0d expected 3 2 2", req_cyc, stall_cyc, bubbles); end
    n_tests++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD || wb_rd !== 5'd7 || wb_RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL load_wb: v %b data %0h rd %0d rw %b expected 1 dead 7 1", wb_valid, wb_data, wb_rd, wb_RegWrite); end
    n_tests++; if (ALU_result_mem !== 64'h77 || rd_mem !== 5'd9 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL load_next: alu %0h rd %0d req %b expected 77 9 0", ALU_result_mem, rd_mem, dmem_req); end
    drive(bubble());
    tick();
    n_tests++; if (wb_data !== 64'h77 || wb_rd !== 5'd9 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL load_follow: data %0h rd %0d v %b expected 77 9 1", wb_data, wb_rd, wb_valid); end
  endtask

  task automatic test_store_fast();
    drive(mk(1, 1, 0, 1, 0, 5'd11, 64'h108, 64'h55));
    tick();
    drive(bubble());
    dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
    #1;
    n_tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 64'h55 || dmem_addr !== 64'h108 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL store_bus: req %b we %b wdata %0h addr %0h stall %b expected 1 1 55 108 0",
                         dmem_req, dmem_we, dmem_wdata, dmem_addr, mem_stall); end
    tick();
    dmem_ack = 1'b0;
    n_tests++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL store_wb: v %b rw %b req %b expected 1 0 0", wb_valid, wb_RegWrite, dmem_req); end
  endtask

  task automatic test_misaligned();
    drive(mk(1, 1, 1, 0, 1, 5'd3, 64'h103, 64'h0));
    tick();
    drive(bubble());
    #1;
    n_tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL mis_noreq: req %b stall %b expected 0 0", dmem_req, mem_stall); end
    tick();
    n_tests++; if (misalign_err !== 1'b1 || wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_rd !== 5'd3) begin
      n_fail++; $display("FAIL mis_wb: err %b v %b rw %b rd %0d expected 1 1 0 3", misalign_err, wb_valid, wb_RegWrite, wb_rd); end
    tick();
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b expected 0", misalign_err); end
  endtask

  task automatic test_reset_in_wait();
    drive(mk(1, 1, 1, 0, 1, 5'd12, 64'h200, 64'h0));
    tick();
    drive(bubble());
    tick();
    n_tests++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
      n_fail++; $display("FAIL rw_pre: req %b stall %b expected 1 1", dmem_req, mem_stall); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_drop: req %b stall %b wbv %b expected 0 0 0", dmem_req, mem_stall, wb_valid); end
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'hCAFE;
    tick();
    dmem_ack = 1'b0;
    n_tests++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 64'd0) begin
      n_fail++; $display("FAIL rw_lateack: req %b wbv %b data %0h expected 0 0 0", dmem_req, wb_valid, wb_data); end
  endtask

  task automatic test_back_to_back();
    drive(mk(1, 1, 1, 0, 1, 5'd4, 64'h300, 64'h0));
    tick();
    drive(mk(1, 1, 1, 0, 1, 5'd6, 64'h308, 64'h0));
    dmem_ack = 1'b1; dmem_rdata = 64'hAAAA;
    tick();
    drive(bubble());
    dmem_ack = 1'b0;
    #1;
    n_tests++; if (wb_data !== 64'hAAAA || wb_rd !== 5'd4 || dmem_req !== 1'b1 || dmem_addr !== 64'h308 || mem_stall !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: data %0h rd %0d req %b addr %0h stall %b expected aaaa 4 1 308 1",
                         wb_data, wb_rd, dmem_req, dmem_addr, mem_stall); end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 64'hBBBB;
    tick();
    dmem_ack = 1'b0;
    n_tests++; if (wb_data !== 64'hBBBB || wb_rd !== 5'd6 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: data %0h rd %0d v %b expected bbbb 6 1", wb_data, wb_rd, wb_valid); end
  endtask

  // Transaction-level model: one entry in MEM, which either retires on its
  // edge (non-memory / misaligned) or waits for the bus acknowledge.
  task automatic test_random();
    ins_t        cur, ment;
    logic        pend, ack, stall, retire, mis, e_rw, e_mis;
    logic [63:0] rdata, e_data;
    int          wcnt, lat;
    do_reset();
    ment = bubble(); pend = 1'b0; wcnt = 0; lat = 0;
    cur  = rand_ins();
    for (int c = 0; c < 600; c++) begin
      ack   = pend ? (wcnt == lat) : ($urandom_range(0, 4) == 0);
      rdata = pend ? mem_val(ment.alu) : {$urandom, $urandom};
      drive(cur); dmem_ack = ack; dmem_rdata = rdata;
      #1;
      n_tests++; if (dmem_req !== pend || mem_stall !== (pend && !ack)) begin
        n_fail++; $display("FAIL rnd_bus[%0d]: req %b stall %b expected %b %b", c, dmem_req, mem_stall, pend, pend && !ack); end
      if (pend) begin
        n_tests++; if (dmem_addr !== ment.alu || dmem_we !== ment.mw || (ment.mw && dmem_wdata !== ment.wd)) begin
          n_fail++; $display("FAIL rnd_addr[%0d]: addr %0h we %b wdata %0h expected %0h %b %0h",
                             c, dmem_addr, dmem_we, dmem_wdata, ment.alu, ment.mw, ment.wd); end
      end
      mis    = (ment.mr || ment.mw) && (ment.alu[2:0] != 3'b000);
      retire = pend ? ack : ment.v;
      e_rw   = retire && ment.rw && !ment.mw && !mis;
      e_data = (pend && ment.m2r) ? rdata : ment.alu;
      e_mis  = !pend && ment.v && mis;
      stall  = pend && !ack;
      if (!stall) begin
        ment = cur;
        pend = cur.v && (cur.mr || cur.mw) && (cur.alu[2:0] == 3'b000);
        wcnt = 0; lat = $urandom_range(0, 3);
        cur  = rand_ins();
      end else wcnt++;
      tick();
      n_tests++; if (wb_valid !== retire || wb_RegWrite !== e_rw || misalign_err !== e_mis) begin
        n_fail++; $display("FAIL rnd_wbctl[%0d]: v %b rw %b mis %b expected %b %b %b", c, wb_valid, wb_RegWrite, misalign_err, retire, e_rw, e_mis); end
      if (retire) begin
        n_tests++; if (wb_data !== e_data || wb_rd !== ment.rd && 1'b0 || wb_data !== e_data) begin
          n_fail++; $display("FAIL rnd_wbdata[%0d]: data %0h expected %0h", c, wb_data, e_data); end
      end
      n_tests++; if (RegWrite_mem !== (ment.v && ment.rw) || (ment.v && (rd_mem !== ment.rd || ALU_result_mem !== ment.alu || MemRead_mem !== ment.mr))) begin
        n_fail++; $display("FAIL rnd_exmem[%0d]: rw %b rd %0d alu %0h expected %b %0d %0h", c, RegWrite_mem, rd_mem, ALU_result_mem, ment.v && ment.rw, ment.rd, ment.alu); end
    end
    drive(bubble()); dmem_ack = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cyc = 0;
    do_reset();
    drive(mk(1, 1, 1, 0, 1, 5'd8, 64'h400, 64'h0));
    tick();
    drive(bubble());
    for (int c = 0; c < 40 && dmem_req === 1'b1; c++) begin
      req_cyc++;
      tick();
    end
    n_tests++; if (req_cyc != 16 || timeout_err !== 1'b1 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL timeout: wait %0d err %b stall %b expected 16 1 0", req_cyc, timeout_err, mem_stall); end
    n_tests++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL timeout_wb: v %b rw %b expected 1 0", wb_valid, wb_RegWrite); end
    tick();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 0", timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_fast();
    test_misaligned();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- EX/MEM pipeline register plus load/store access unit; sits directly downstream of the execute stage and consumes its ALU result and store data.
- Drives a request/acknowledge data-memory bus with variable latency.
- Freezes the upstream pipeline while an access is outstanding.
- Feeds the MEM/WB register outputs and the rd/RegWrite/ALU-result signals used by the forwarding unit.

Parameters:
XLEN, 64, datapath and address width
TIMEOUT_CYCLES, 16, wait-cycle limit before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
valid_ex  input  1  EX holds a real instruction
ALU_result_ex  input  XLEN  ALU result / effective address
write_data_ex  input  XLEN  forwarded store data
rd_ex  input  5  destination register
RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex  input  1 each  control bits
ALU_result_mem  output  XLEN  latched ALU result (to forwarding mux)
rd_mem  output  5  latched rd
RegWrite_mem  output  1  latched RegWrite AND latched valid
MemRead_mem  output  1  latched load flag (to hazard unit)
mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
dmem_req, dmem_we  output  1 each  bus request, write enable
dmem_addr, dmem_wdata  output  XLEN  bus address, store data
dmem_ack  input  1  bus completion, single-cycle pulse
dmem_rdata  input  XLEN  load data, valid with ack
wb_valid, wb_RegWrite  output  1 each  MEM/WB register
wb_rd  output  5  MEM/WB destination
wb_data  output  XLEN  MEM/WB result: rdata if MemtoReg, else ALU result
misalign_err  output  1  one-cycle pulse, misaligned access dropped

Behaviour:
- Reset: asynchronous on rst_n low. Clears all registers and every output to 0; FSM goes to IDLE; mem_stall = 0.
- EX/MEM register: loads on clk when mem_stall = 0. It holds while mem_stall = 1.
- FSM states:
  - IDLE: at the capture edge, if the incoming entry is valid, (MemRead|MemWrite), and ALU_result_ex[2:0] == 0, go to WAIT.
  - WAIT: dmem_req = 1. dmem_we = latched MemWrite. dmem_addr and dmem_wdata come from the latched entry and stay stable until ack.
  - WAIT -> IDLE on a clk edge with dmem_ack = 1.
- mem_stall = (state == WAIT) && !dmem_ack. This is combinational, so the EX/MEM register accepts the next entry on the same edge the ack is sampled.
- Latency: non-memory op reaches the WB outputs 1 cycle after EX/MEM capture. A memory op reaches them at the ack edge; minimum is 1 cycle if ack arrives in the first WAIT cycle.
- MEM/WB register, updated every edge:
  - Completing entry (non-memory in IDLE, or ack in WAIT): wb_valid = 1, fields copied.
  - While mem_stall = 1: bubble, wb_valid = 0 and wb_RegWrite = 0.
- Stores: wb_RegWrite = 0 regardless of input.
- Misaligned access: no request and no WAIT. Entry passes to WB with wb_valid = 1, wb_RegWrite = 0. misalign_err pulses in the same cycle as the WB update.
- dmem_ack in IDLE is ignored, including a stale ack after reset.
- Invalid entries (valid_ex = 0) never request. RegWrite_mem = 0 and wb_valid = 0 for them.
- Reset during WAIT: request drops immediately; the transaction is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A counter (width clog2(TIMEOUT_CYCLES)+1) clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES with no ack, the FSM returns to IDLE and mem_stall releases.
  - The entry retires with wb_RegWrite = 0; output timeout_err pulses for 1 cycle.
- When undefined: no counter and no timeout_err port; WAIT persists until ack.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN constant
  - 1-bit state encoding (IDLE = 0, WAIT = 1)
  - a typedef for the EX/MEM control bundle (valid, RegWrite, MemRead, MemWrite, MemtoReg, rd)
- One natural sub-module, dmem_fsm: owns the state, the timeout counter, dmem_req/dmem_we, and mem_stall generation.
- The pipeline registers stay in the top module.

Test Plan:
- ALU op: rd_ex = 5, RegWrite_ex = 1, ALU_result_ex = 0x2A -> next cycle RegWrite_mem = 1, rd_mem = 5, ALU_result_mem = 0x2A; following cycle wb_data = 0x2A, wb_valid = 1, mem_stall never high.
- Load at 0x100, ack after 3 cycles with rdata = 0xDEAD -> dmem_req high 3 cycles, mem_stall high 2 cycles, two bubbles, then wb_data = 0xDEAD, wb_rd correct, next instruction captured on the ack edge.
- Store at 0x108 with data 0x55, ack on the first WAIT cycle -> dmem_we = 1, dmem_wdata = 0x55; on the ack edge wb_valid = 1, wb_RegWrite = 0.
- Load at 0x103 -> no dmem_req, misalign_err = 1 for one cycle, wb_RegWrite = 0.
- rst_n low during the second WAIT cycle -> dmem_req, mem_stall, and wb_valid all 0 immediately; a later ack pulse is ignored.
- With MEM_TIMEOUT_EN and no ack -> after 16 WAIT cycles, timeout_err pulses and mem_stall drops.
